// File: rtl/irq_arb_pkg.sv
// irq_arbiter shared types: FSM states and
// configuration register addresses.
package irq_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP
  } state_t;

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_MODE    = 2'd1;
  localparam logic [1:0] ADDR_PENDING = 2'd2;
  localparam logic [1:0] ADDR_SWSET   = 2'd3;

endpackage

// File: rtl/irq_arbiter_if.sv
// Core interrupt port, raw sources and config
// register port of the irq_arbiter.
interface irq_arbiter_if #(
  parameter int N_SRC = 32,
  parameter int ID_W  = 5
);

  logic [N_SRC-1:0] irq_src_i;
  logic             irq_o;
  logic [ID_W-1:0]  irq_id_o;
  logic             irq_ack_i;
  logic [ID_W-1:0]  irq_ack_id_i;
  logic             cfg_we_i;
  logic [1:0]       cfg_addr_i;
  logic [31:0]      cfg_wdata_i;
  logic [31:0]      cfg_rdata_o;
  logic [31:0]      ack_count_o;

  modport slave (
    input  irq_src_i,
    input  irq_ack_i,
    input  irq_ack_id_i,
    input  cfg_we_i,
    input  cfg_addr_i,
    input  cfg_wdata_i,
    output irq_o,
    output irq_id_o,
    output cfg_rdata_o,
    output ack_count_o
  );

  modport master (
    output irq_src_i,
    output irq_ack_i,
    output irq_ack_id_i,
    output cfg_we_i,
    output cfg_addr_i,
    output cfg_wdata_i,
    input  irq_o,
    input  irq_id_o,
    input  cfg_rdata_o,
    input  ack_count_o
  );

endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over
// the eligible interrupt vector.
module irq_prio_enc #(
  parameter int N_SRC = 32,
  parameter int ID_W  = 5
) (
  input  logic [N_SRC-1:0] vec,
  output logic             valid,
  output logic [ID_W-1:0]  id
);

  always_comb begin
    valid = |vec;
    id    = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (vec[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Multi-source interrupt arbiter: pending/enable
// registers and request/ack handshake to the core.
module irq_arbiter
  import irq_arb_pkg::*;
#(
  parameter int N_SRC = 32,
  parameter int ID_W  = 5
) (
  input logic clk_i,
  input logic rst_i,
  irq_arbiter_if.slave bus
);

  localparam logic [N_SRC-1:0] ONE = N_SRC'(1);

  logic [N_SRC-1:0] enable;
  logic [N_SRC-1:0] mode;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] prev;

  logic [N_SRC-1:0] wmask;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] swset;
  logic [N_SRC-1:0] edge_set;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] pend_next;
  logic             we_en;
  logic             we_mode;
  logic             ack_hit;
  logic             sel_valid;
  logic [ID_W-1:0]  sel_id;
  logic [31:0]      rdata;

  state_t           state;
  logic             irq;
  logic [ID_W-1:0]  irq_id;
  logic [31:0]      ack_count;

  assign wmask = bus.cfg_wdata_i[N_SRC-1:0];

  always_comb begin
    we_en   = 1'b0;
    we_mode = 1'b0;
    w1c     = '0;
    swset   = '0;
    if (bus.cfg_we_i) begin
      unique case (1'b1)
        (bus.cfg_addr_i == ADDR_ENABLE):
          we_en = 1'b1;
        (bus.cfg_addr_i == ADDR_MODE):
          we_mode = 1'b1;
        (bus.cfg_addr_i == ADDR_PENDING):
          w1c = wmask;
        (bus.cfg_addr_i == ADDR_SWSET):
          swset = wmask;
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (bus.cfg_addr_i == ADDR_ENABLE):
        rdata[N_SRC-1:0] = enable;
      (bus.cfg_addr_i == ADDR_MODE):
        rdata[N_SRC-1:0] = mode;
      (bus.cfg_addr_i == ADDR_PENDING):
        rdata[N_SRC-1:0] = pending;
      default: ;
    endcase
  end

  assign ack_hit = (state == REQ)
                 && bus.irq_ack_i;

  // Only edge sources hold a bit the ack can clear.
  always_comb begin
    ack_clr = '0;
    if (ack_hit
        && 32'(bus.irq_ack_id_i) < 32'(N_SRC))
      ack_clr = (ONE << bus.irq_ack_id_i)
              & ~mode;
  end

  assign edge_set = bus.irq_src_i & ~prev;

  // Set sources win over any clear in the same cycle.
  assign pend_next =
      (mode & (bus.irq_src_i | swset))
    | (~mode & ((pending & ~(w1c | ack_clr))
               | edge_set | swset));

  assign eligible = pending & enable;

  irq_prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_enc (
    .vec   (eligible),
    .valid (sel_valid),
    .id    (sel_id)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      enable  <= '0;
      mode    <= '0;
      pending <= '0;
      prev    <= '0;
    end else begin
      if (we_en)   enable <= wmask;
      if (we_mode) mode   <= wmask;
      pending <= pend_next;
      prev    <= bus.irq_src_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      irq       <= 1'b0;
      irq_id    <= '0;
      ack_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sel_valid) begin
            irq    <= 1'b1;
            irq_id <= sel_id;
            state  <= REQ;
          end
        end
        REQ: begin
          if (bus.irq_ack_i) begin
            ack_count <= ack_count + 32'd1;
            irq       <= 1'b0;
            state     <= GAP;
          end else if (!sel_valid) begin
            irq   <= 1'b0;
            state <= IDLE;
          end else begin
            irq_id <= sel_id;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          irq   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.irq_o       = irq;
  assign bus.irq_id_o    = irq_id;
  assign bus.cfg_rdata_o = rdata;
  assign bus.ack_count_o = ack_count;

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Multi-source interrupt controller that drives the core's single-request interrupt port (irq request, 5-bit id, ack, ack id).
- Latches per-source events into pending bits and applies per-source enable masks.
- Selects the highest-priority source (lowest index) and runs the request/acknowledge handshake with the core.
- Sits between peripheral/testbench interrupt generators and the core; software configures it through a small register port.

Parameters:
- N_SRC, 32, number of interrupt sources (1..32); the source index is the interrupt id.
- ID_W, 5, id width; must satisfy 2**ID_W >= N_SRC.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, asynchronous, active-high
- irq_src_i  input  N_SRC  raw source lines, synchronous to clk_i
- irq_o  output  1  interrupt request to core
- irq_id_o  output  ID_W  id of requested interrupt
- irq_ack_i  input  1  core accepted an interrupt (1-cycle pulse)
- irq_ack_id_i  input  ID_W  id the core accepted
- cfg_we_i  input  1  register write strobe
- cfg_addr_i  input  2  register select
- cfg_wdata_i  input  32  write data (bits N_SRC-1:0 used)
- cfg_rdata_o  output  32  combinational read data for cfg_addr_i
- ack_count_o  output  32  number of accepted interrupts, wraps at 2**32

Behaviour:
- Reset (async, rst_i=1): all registers 0; state IDLE; irq_o=0, irq_id_o=0, ack_count_o=0; prev-sample register 0. Asserting rst_i mid-handshake drops irq_o immediately and discards all pending bits.
- Registers:
  - addr 0 ENABLE: read/write.
  - addr 1 MODE: read/write; bit=1 level, bit=0 edge.
  - addr 2 PENDING: read; write-1-to-clear.
  - addr 3 SWSET: write-1-to-set pending; reads 0.
  - Bits at N_SRC and above read 0.
- Edge source: the pending bit sets on a rising edge (irq_src_i=1 and previous sample=0). It stays set until acked or cleared by W1C.
- Level source: the pending bit equals the registered irq_src_i, OR-ed with SWSET.
- Priority: among pending & ENABLE, the lowest index wins. Selection is combinational in the priority encoder; irq_id_o is registered.
- Pending-bit precedence in one cycle: new edge or SWSET beats ack-clear and W1C (the bit stays set).
- FSM states:
  - IDLE: if any eligible source, load irq_id_o, set irq_o=1, go to REQ (1-cycle latency from pending to irq_o).
  - REQ: irq_o=1.
    - If a higher-priority source becomes eligible, irq_id_o updates next cycle.
    - If no source is eligible (disabled or cleared), irq_o=0 next cycle and return to IDLE.
    - On irq_ack_i: clear the edge-mode pending bit irq_ack_id_i, increment ack_count_o, set irq_o=0, go to GAP.
  - GAP: exactly 1 cycle with irq_o=0, then IDLE. This guarantees the core sees the request deassert between interrupts.
- irq_ack_i received outside REQ: ignored, no count.
- Ack with an id that is not pending: ack_count_o still increments; no pending bit changes.
- An enabled level source still high after ack re-requests: GAP, IDLE, then REQ again.
- irq_ack_id_i >= N_SRC: no pending change.

Decomposition:
- Package irq_arb_pkg:
  - state enum {IDLE, REQ, GAP};
  - register address constants ADDR_ENABLE=0, ADDR_MODE=1, ADDR_PENDING=2, ADDR_SWSET=3.
- Sub-module irq_prio_enc: N_SRC-bit vector in, outputs valid and ID_W-bit lowest-set index; purely combinational.

Test Plan:
- ENABLE=0x3, MODE=0. Pulse src[1], then 2 cycles later pulse src[0] before ack -> irq_o=1 with id 1, then id changes to 0. Ack id 0 -> pending=0x2, GAP cycle, re-request with id 1. Ack id 1 -> ack_count_o=2.
- MODE bit 4=1, ENABLE=0x10, hold src[4] high -> repeated request/ack cycles, each separated by 1 cycle of irq_o=0. Drop src[4] -> irq_o stays 0.
- Pending src[2] with ENABLE=0 -> irq_o=0 and PENDING reads 0x4. Write ENABLE=0x4 -> irq_o=1, id 2, one cycle later.
- SWSET=0x80000000, ENABLE all -> id 31 requested. In the same cycle apply W1C on bit 31 and an ack -> pending bit stays cleared and the count increments once.
- Edge on src[3] in the same cycle as ack id 3 -> pending[3] remains 1 and is re-requested after GAP.
- rst_i asserted while irq_o=1 -> irq_o=0, all registers 0 in the same cycle, no request after release until a new event.
